// File: rtl/sr_cmd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sr_cmd_pkg
// Description : Shared types and constants for the SR command debouncer.
// Revision    : 1.0  initial release
// ============================================================================
package sr_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        PRESSED   = 2'd2,
        REL_CHK   = 2'd3
    } ch_state_t;

    localparam int PRI_RESET = 0;
    localparam int PRI_SET   = 1;

endpackage
`default_nettype wire

// File: rtl/sr_cmd_debouncer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sr_cmd_debouncer_if
// Description : Raw button inputs and SR command outputs of the debouncer.
// Revision    : 1.0  initial release
// ============================================================================
interface sr_cmd_debouncer_if;

    logic set_raw;
    logic clr_raw;
    logic s;
    logic r;
    logic conflict;

    modport master (output set_raw, output clr_raw, input s, input r, input conflict);
    modport slave  (input set_raw, input clr_raw, output s, output r, output conflict);

endinterface
`default_nettype wire

// File: rtl/sr_debounce_channel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sr_debounce_channel
// Description : 2-flop synchroniser plus press/release debounce FSM; one
//               registered evt pulse per accepted press.
// Revision    : 1.0  initial release
// ============================================================================
module sr_debounce_channel
    import sr_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic evt
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             evt_q, evt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            evt_q   <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
        end
    end

    // Press and release are both qualified, so release bounce cannot re-arm.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    cnt_d   = c_CNT_ONE;
                    state_d = PRESS_CHK;
                end
            end
            PRESS_CHK: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == c_CNT_LAST) begin
                    state_d = PRESSED;
                    evt_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    cnt_d   = c_CNT_ONE;
                    state_d = REL_CHK;
                end
            end
            REL_CHK: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                end else if (cnt_q == c_CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign evt = evt_q;

endmodule
`default_nettype wire

// File: rtl/sr_cmd_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sr_cmd_debouncer
// Description : Debounces set/clear buttons and issues mutually exclusive
//               one-cycle s/r commands with a fixed-priority arbiter.
// Revision    : 1.0  initial release
// ============================================================================
module sr_cmd_debouncer
    import sr_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SET_PRIORITY    = 0,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    sr_cmd_debouncer_if.slave    bus
);

    localparam logic c_SET_WINS = (SET_PRIORITY == PRI_SET);

    logic set_evt;
    logic clr_evt;
    logic s_q, s_d;
    logic r_q, r_d;
    logic conflict_q, conflict_d;

    sr_debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_set_ch (
        .clk (clk),
        .rst (rst),
        .raw (bus.set_raw),
        .evt (set_evt)
    );

    sr_debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_clr_ch (
        .clk (clk),
        .rst (rst),
        .raw (bus.clr_raw),
        .evt (clr_evt)
    );

    // A losing event is dropped outright; it is never held for a later cycle.
    always_comb begin
        s_d        = set_evt & (~clr_evt |  c_SET_WINS);
        r_d        = clr_evt & (~set_evt | ~c_SET_WINS);
        conflict_d = set_evt & clr_evt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.s        = s_q;
    assign bus.r        = r_q;
    assign bus.conflict = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_cmd_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sr_cmd_debouncer
// Description : Self-checking bench; two DUTs (reset-priority, set-priority).
// Revision    : 1.0  initial release
// ============================================================================
module tb_sr_cmd_debouncer;

    localparam int D = 4;

    logic clk;
    logic rst;
    logic set_in;
    logic clr_in;

    int checks = 0;
    int errors = 0;

    sr_cmd_debouncer_if bus0 ();
    sr_cmd_debouncer_if bus1 ();

    assign bus0.set_raw = set_in;
    assign bus0.clr_raw = clr_in;
    assign bus1.set_raw = set_in;
    assign bus1.clr_raw = clr_in;

    sr_cmd_debouncer #(.DEBOUNCE_CYCLES(D), .SET_PRIORITY(0)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    sr_cmd_debouncer #(.DEBOUNCE_CYCLES(D), .SET_PRIORITY(1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    logic [2:0] outs [2];
    assign outs[0] = {bus0.s, bus0.r, bus0.conflict};
    assign outs[1] = {bus1.s, bus1.r, bus1.conflict};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Reference model: a channel accepts a new level once the synchronised
    // level (raw delayed two edges) has differed from the accepted level for
    // D consecutive edges; accepting a 1 is an event, shown one edge later.
    logic [1:0] m_h1, m_h2, m_acc, m_evt_prev, m_evt_new, m_raw;
    logic       m_lvl;
    int         m_run [2];
    logic [2:0] m_exp [2];

    initial begin : model
        m_h1 = '0; m_h2 = '0; m_acc = '0; m_evt_prev = '0; m_evt_new = '0;
        m_run[0] = 0; m_run[1] = 0;
        m_exp[0] = '0; m_exp[1] = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_h1 = '0; m_h2 = '0; m_acc = '0; m_evt_prev = '0;
                m_run[0] = 0; m_run[1] = 0;
                m_exp[0] = '0; m_exp[1] = '0;
            end else begin
                m_raw     = {clr_in, set_in};
                m_evt_new = '0;
                for (int ch = 0; ch < 2; ch++) begin
                    m_lvl     = m_h2[ch];
                    m_h2[ch]  = m_h1[ch];
                    m_h1[ch]  = m_raw[ch];
                    if (m_lvl != m_acc[ch]) begin
                        m_run[ch]++;
                        if (m_run[ch] == D) begin
                            m_acc[ch]       = m_lvl;
                            m_run[ch]       = 0;
                            m_evt_new[ch]   = m_lvl;
                        end
                    end else begin
                        m_run[ch] = 0;
                    end
                end
                for (int d = 0; d < 2; d++) begin
                    if (m_evt_prev == 2'b11)
                        m_exp[d] = (d == 1) ? 3'b101 : 3'b011;
                    else
                        m_exp[d] = {m_evt_prev[0], m_evt_prev[1], 1'b0};
                end
                m_evt_prev = m_evt_new;
            end
        end
    end

    // Pulse statistics and an SR flip-flop stand-in driven by each DUT.
    int s_cnt [2];
    int r_cnt [2];
    int c_cnt [2];
    int s_last [2];
    int s_prev [2];
    logic q [2];

    initial begin : compare
        for (int d = 0; d < 2; d++) begin
            s_cnt[d] = 0; r_cnt[d] = 0; c_cnt[d] = 0;
            s_last[d] = 0; s_prev[d] = 0; q[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check($sformatf("dut%0d_s_r_conflict", d), int'(outs[d]),
                      rst ? 0 : int'(m_exp[d]));
                check($sformatf("dut%0d_s_and_r", d), int'(outs[d][2] & outs[d][1]), 0);
                if (outs[d][2]) begin
                    s_cnt[d]++;
                    s_prev[d] = s_last[d];
                    s_last[d] = int'($time);
                    q[d] = 1'b1;
                end
                if (outs[d][1]) begin
                    r_cnt[d]++;
                    q[d] = 1'b0;
                end
                if (outs[d][0]) c_cnt[d]++;
            end
        end
    end

    int t_ref;
    int base;

    initial begin : stimulus
        rst = 1'b1; set_in = 1'b0; clr_in = 1'b0;
        #2 rst = 1'b0;

        // Steady press from 12 ns: first sampling edge 15 ns, pulse after 75 ns edge.
        #10 set_in = 1'b1;
        tick(9);
        check("t1_s_count", s_cnt[0], 1);
        check("t1_s_time_dut0", s_last[0], 80);
        check("t1_s_time_dut1", s_last[1], 80);
        check("t1_q", int'(q[0]), 1);
        check("t1_r_count", r_cnt[0], 0);
        check("t1_conflict", c_cnt[0] + c_cnt[1], 0);
        set_in = 1'b0;
        tick(10);

        // Bounce 1-0-1-0 then steady high.
        base = s_cnt[0];
        set_in = 1'b1; tick(1); set_in = 1'b0; tick(1);
        set_in = 1'b1; tick(1); set_in = 1'b0; tick(1);
        set_in = 1'b1; t_ref = int'($time);
        tick(10);
        check("t2_s_count", s_cnt[0] - base, 1);
        check("t2_latency", s_last[0] - t_ref, 73);
        set_in = 1'b0;
        tick(10);

        // 3-cycle clear glitch, then a real clear press.
        clr_in = 1'b1; tick(3); clr_in = 1'b0; tick(10);
        check("t3_glitch_r_count", r_cnt[0], 0);
        check("t3_glitch_q", int'(q[0]), 1);
        clr_in = 1'b1; tick(10);
        check("t3_r_count", r_cnt[0], 1);
        check("t3_q_dut0", int'(q[0]), 0);
        check("t3_q_dut1", int'(q[1]), 0);
        clr_in = 1'b0;
        tick(10);

        // Simultaneous press: dut0 reset wins, dut1 set wins.
        set_in = 1'b1; clr_in = 1'b1; tick(10);
        check("t4_conflict_dut0", c_cnt[0], 1);
        check("t4_conflict_dut1", c_cnt[1], 1);
        check("t4_r_count_dut0", r_cnt[0], 2);
        check("t4_s_count_dut0", s_cnt[0], 2);
        check("t4_s_count_dut1", s_cnt[1], 3);
        check("t4_r_count_dut1", r_cnt[1], 1);
        check("t4_q_dut0", int'(q[0]), 0);
        check("t4_q_dut1", int'(q[1]), 1);
        set_in = 1'b0; clr_in = 1'b0;
        tick(10);

        // Long hold, bouncy release, second press 60 cycles after the first.
        base = s_cnt[0];
        set_in = 1'b1; tick(50);
        set_in = 1'b0; tick(1); set_in = 1'b1; tick(1);
        set_in = 1'b0; tick(1); set_in = 1'b1; tick(1);
        set_in = 1'b0; tick(6);
        set_in = 1'b1; tick(12);
        check("t5_s_count", s_cnt[0] - base, 2);
        check("t5_spacing", s_last[0] - s_prev[0], 600);
        check("t5_min_spacing", int'((s_last[0] - s_prev[0]) >= 2 * D * 10), 1);
        set_in = 1'b0;
        tick(10);

        // Reset while the press counter is at 2, button still held.
        base = s_cnt[0];
        set_in = 1'b1; tick(4);
        rst = 1'b1;
        @(negedge clk); #1;
        check("t6_rst_out_dut0", int'(outs[0]), 0);
        check("t6_rst_out_dut1", int'(outs[1]), 0);
        tick(2);
        rst = 1'b0; t_ref = int'($time);
        tick(10);
        check("t6_s_count", s_cnt[0] - base, 1);
        check("t6_latency", s_last[0] - t_ref, 73);
        set_in = 1'b0;
        tick(10);

        // Randomised segments with occasional asynchronous reset.
        for (int i = 0; i < 300; i++) begin
            set_in = 1'($urandom_range(0, 1));
            clr_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                #($urandom_range(0, 6)) rst = 1'b1;
                tick($urandom_range(1, 2));
                rst = 1'b0;
            end
            tick($urandom_range(1, 12));
        end
        set_in = 1'b0; clr_in = 1'b0;
        tick(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sr_cmd_debouncer.md
Name: sr_cmd_debouncer

Overview:
Upstream command stage for sr_flip_flop. Takes two raw, asynchronous, bouncy push-button inputs (set, clear) and synchronises and debounces each one. It emits one-cycle s / r command pulses that drive the flip-flop's s and r inputs directly. It guarantees the flip-flop never sees s=1, r=1 together; simultaneous requests are resolved by a fixed priority.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive clk cycles a synchronised input must hold a new level before it is accepted; legal range 2..65535.
SET_PRIORITY, 0, simultaneous-event winner: 0 = reset (r) wins, 1 = set (s) wins.
CNT_W, $clog2(DEBOUNCE_CYCLES+1), derived debounce counter width; not to be overridden.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
set_raw  input  1  raw set button, asynchronous to clk, may bounce
clr_raw  input  1  raw clear button, asynchronous to clk, may bounce
s  output  1  registered one-cycle set command to sr_flip_flop.s
r  output  1  registered one-cycle reset command to sr_flip_flop.r
conflict  output  1  registered one-cycle flag: both events occurred in the same cycle and one was dropped

Behaviour:
- Reset (async assert, sync release):
  - s, r and conflict are 0.
  - Both synchroniser flops are 0.
  - Both channel FSMs are IDLE with counters at 0.
- Synchroniser: 2-flop chain per raw input; no logic between the two flops.
- Channel FSM, one per input, operating on the synchronised level `lvl`:
  - IDLE: if lvl=1, load cnt=1 and go to PRESS_CHK.
  - PRESS_CHK: if lvl=0, go to IDLE. Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED and pulse `evt` for 1 cycle. Else cnt++.
  - PRESSED: if lvl=0, load cnt=1 and go to REL_CHK.
  - REL_CHK: if lvl=1, go to PRESSED. Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE. Else cnt++.
- Channel properties:
  - Exactly one evt per accepted press, no matter how long the button is held.
  - Release is debounced, so release bounce never produces a second evt.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no evt.
- Arbiter, registered output stage:
  - set_evt only: s=1 next cycle.
  - clr_evt only: r=1 next cycle.
  - Both events in the same cycle: the winner selected by SET_PRIORITY pulses, the loser is dropped permanently (not queued), and conflict=1 in the same cycle as the winner.
  - Invariant: s&r is never 1 in any cycle.
- Latency: raw input rises and stays stable before edge E0 → output pulse is high during the cycle after edge E0+DEBOUNCE_CYCLES+2. That is DEBOUNCE_CYCLES+3 edges total: 2 synchroniser + DEBOUNCE_CYCLES debounce + 1 output register.
- Pulse width: s, r and conflict are each high for exactly one cycle per event.
- Back-to-back presses: the next press cannot be accepted until the release is confirmed. Minimum spacing between two s pulses is 2*DEBOUNCE_CYCLES cycles.
- Reset mid-operation:
  - All partial counts are discarded.
  - A raw input still held high when reset is released is treated as a new press and yields a pulse after the nominal latency.
- Counter saturation: not possible. cnt never exceeds DEBOUNCE_CYCLES-1, so the counter cannot wrap.

Decomposition:
- Package sr_cmd_pkg holds:
  - enum ch_state_t {IDLE, PRESS_CHK, PRESSED, REL_CHK} (2-bit encoding).
  - localparams PRI_RESET=0 and PRI_SET=1.
- Sub-module sr_debounce_channel contains the synchroniser, FSM and counter.
  - Ports: clk, rst, raw, evt.
  - Instantiated twice.
- The top level adds only the arbiter and the output registers.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, giving a 7-edge latency. The bench instantiates sr_cmd_debouncer driving sr_flip_flop, with a 10 ns clk.
1. Hold set_raw=1 from t=12 ns → s is high for exactly one cycle, in the 7th cycle after the first sampling edge. q goes 1. r stays 0 and conflict stays 0.
2. set_raw bounce of 1-0-1-0 (each level 1 cycle), then a steady 1 → no pulse during the bounce. A single s pulse appears 7 edges after the steady level begins.
3. clr_raw glitch of 3 cycles high, then 0 → no r pulse and q unchanged. Then clr_raw held high → one r pulse and q goes 0.
4. Both raw inputs rise on the same cycle:
   - SET_PRIORITY=0: r=1, s=0, conflict=1 in the same cycle; q goes 0.
   - Repeat with SET_PRIORITY=1: s=1, conflict=1; q goes 1.
5. set_raw held high for 50 cycles, released with bounce, then pressed again → exactly two s pulses total, spaced at least 8 cycles apart.
6. Assert rst during PRESS_CHK (cnt=2) with set_raw held high → s, r and conflict are 0 during reset. After release, one s pulse appears 7 edges later. s&r==0 is asserted every cycle throughout all tests.
